// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the data-memory interface. Takes one RV32I
//               load/store per handshake and generates the word address,
//               byte enables and lane-shifted store data. It then waits for
//               mem_ack and returns a one-cycle response that carries the
//               sign/zero-extended load data.
//
//   Ports:
//     clk, reset             clock / asynchronous active-high reset
//     req_valid/req_ready    request handshake from the execute stage
//     req_we, req_funct3     store flag and RV32I width/sign code
//     req_addr, req_wdata    byte address, right-aligned store data
//     resp_valid/rdata/err   one-cycle completion pulse with load data / error
//     mem_req/we/addr/be     word-organised memory request (held until ack)
//     mem_wdata, mem_rdata   lane-aligned write data / read word
//     mem_ack                completes the current memory transaction
//
//   Optional feature macro:
//     LSU_MISALIGN_SPLIT_EN  defined   -> word-crossing accesses are split
//                                         into two memory transactions
//                            undefined -> misaligned accesses return resp_err
//
// Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_acc0 = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] c_acc1 = 2'd2;
`endif
    localparam logic [1:0] c_resp = 2'd3;
    localparam logic [ADDR_WIDTH-3:0] c_word_step = 1;

    logic [1:0] r_state;
    logic [1:0] r_off;
    logic [2:0] r_funct3;

    logic [3:0] w_mask;
    logic       w_illegal;
    logic       w_misalign;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [3:0]            r_mask;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [2:0]            w_size;
    logic [2:0]            w_rem;
    logic                  w_cross;
`endif

    assign req_ready = (r_state == c_idle);

    // Request decode, evaluated only while IDLE.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
        // Stores: only sb/sh/sw. Loads: 011, 110 and 111 are undefined.
        if (req_we)
            w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            w_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1]);
`ifdef LSU_MISALIGN_SPLIT_EN
        w_misalign = 1'b0;
`else
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Second-half geometry of a word-crossing access, from the latched request.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            default: w_size = 3'd4;
        endcase
        w_cross = ({1'b0, r_off} + w_size) > 3'd4;
        w_rem   = 3'd4 - {1'b0, r_off};
    end
`endif

    // Bytes {word1[23:0], word0} are shifted down by the byte offset, then
    // truncated to the access size and extended according to funct3.
    function automatic logic [31:0] f_load_data(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [55:0] bytes);
        logic [31:0] v;
        v = 32'(bytes >> {off, 3'b000});
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b100:  return {24'h0, v[7:0]};
            3'b101:  return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_idle;
            r_off      <= 2'b00;
            r_funct3   <= 3'b000;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_mask     <= 4'b0000;
            r_wdata    <= '0;
            r_rdata0   <= '0;
`endif
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req_valid) begin
                        r_off    <= req_addr[1:0];
                        r_funct3 <= req_funct3;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_mask   <= w_mask;
                        r_wdata  <= req_wdata;
`endif
                        if (w_illegal || w_misalign) begin
                            // Rejected without touching memory.
                            r_state    <= c_resp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            r_state   <= c_acc0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_addr[ADDR_WIDTH-1:2];
                            mem_be    <= w_mask << req_addr[1:0];
                            mem_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                        end
                    end
                end
                c_acc0: begin
                    if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (w_cross) begin
                            // Keep mem_req high and move to the next word.
                            r_state   <= c_acc1;
                            r_rdata0  <= mem_rdata;
                            mem_addr  <= mem_addr + c_word_step;
                            mem_be    <= r_mask >> w_rem;
                            mem_wdata <= r_wdata >> {w_rem, 3'b000};
                        end else
`endif
                        begin
                            r_state    <= c_resp;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_be     <= 4'b0000;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= mem_we ? '0 :
                                          f_load_data(r_funct3, r_off, {24'h0, mem_rdata});
                        end
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                c_acc1: begin
                    if (mem_ack) begin
                        r_state    <= c_resp;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= 4'b0000;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_we ? '0 :
                                      f_load_data(r_funct3, r_off, {mem_rdata[23:0], r_rdata0});
                    end
                end
`endif
                c_resp: begin
                    r_state    <= c_idle;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Sits between the execute stage and a word-organised data RAM with byte enables.
- Accepts one load/store per handshake, decoded by RV32I funct3. Generates word address, byte enables and lane-shifted store data. Waits for the memory acknowledge.
- Returns sign/zero-extended load data, or store completion, as a one-cycle response.
- Optionally splits word-crossing accesses into two memory transactions.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr.
- DATA_WIDTH, 32, data width; only 32 is supported (4 byte lanes).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: illegal funct3, or misaligned access when split is disabled.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH-2  word address.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-aligned store data.
- mem_rdata  in  DATA_WIDTH  read word; valid in the cycle mem_ack is high.
- mem_ack  in  1  completes the current memory transaction.

Behaviour:
- Reset (async, active-high): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- Reset asserted mid-transaction aborts it: no response is issued and mem_req drops immediately.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1. Request accepted on a rising edge with req_valid=1.
  - Decode at acceptance: off=addr[1:0]; size 1/2/4 bytes; mask 0001/0011/1111.
  - Illegal funct3 (store not 000/001/010; load 011/110/111) -> RESP with err; no memory access.
  - Otherwise -> ACC0.
- ACC0:
  - mem_req=1; mem_addr=addr[ADDR_WIDTH-1:2]; mem_be=(mask<<off)[3:0]; mem_wdata=wdata<<(8*off); mem_we=req_we.
  - All mem_* outputs are registered and held stable until mem_ack.
  - On mem_ack: capture mem_rdata. If the access crosses a word (off+size>4) -> ACC1, else -> RESP.
- ACC1:
  - mem_addr=word+1 (wraps modulo 2^(ADDR_WIDTH-2)); mem_be=mask>>(4-off); mem_wdata=wdata>>(8*(4-off)).
  - On mem_ack: capture mem_rdata, then -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then -> IDLE; req_ready=0.
  - Load: bytes are assembled from {word1,word0}>>(8*off), truncated to size, then sign-extended (b/h) or zero-extended (bu/hu/w).
- mem_req deasserts in the cycle after the final mem_ack; there is no back-to-back request without an IDLE cycle.
- Latency, aligned access with immediate ack: acceptance edge E0; mem_req high E0→E1, ack sampled at E1; resp_valid high E1→E2. Each memory wait cycle adds 1.
- req_ready=0 in ACC0/ACC1/RESP; req_valid is ignored there.
- mem_ack outside ACC0/ACC1 is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: a word-crossing access (lh/lhu/sh at off=3; lw/sw at off≠0) performs ACC0 then ACC1 as above. resp_err=0.
- Undefined: any access with off%size≠0 goes IDLE->RESP with resp_err=1 and resp_rdata=0, and no mem_req. ACC1 is not built. Aligned accesses are unaffected.

Test Plan:
- Reset mid-ACC0 (mem_req=1, no ack) -> mem_req=0 immediately; after release req_ready=1 and no resp_valid pulse.
- sb addr=0x103, wdata=0x000000A5, ack immediate -> mem_addr=0x40, mem_be=1000, mem_wdata=0xA5000000; resp_valid one cycle later, rdata=0.
- lb addr=0x102, mem_rdata=0x00800000 -> resp_rdata=0xFFFFFF80. lbu at the same address -> 0x00000080. lhu addr=0x102, mem_rdata=0x8001_0000 -> 0x00008001.
- lw addr=0x8, ack delayed 3 cycles -> mem_req/mem_addr/mem_be stable through the wait; resp_valid exactly 1 cycle after the ack edge; rdata = mem_rdata.
- With LSU_MISALIGN_SPLIT_EN: lw addr=0x5, words 0x1 = 0xDDCCBBAA and 0x2 = 0x44332211 -> two transactions, be 1110 then 0001; resp_rdata=0x11DDCCBB.
  - Same stimulus without the macro -> no mem_req; resp_err=1, rdata=0.
- Store with funct3=011 -> no mem_req; resp_valid with resp_err=1. Back-to-back req_valid held high -> second request accepted only after the IDLE cycle.
